gfx_dma_writer: RTL and testbench

CPU-side write engine of the gfx module: the DMA end of the VRAM/palette bus that the VGA scanout reads. It accepts byte writes through a 4-register CPU port and buffers them in a small FIFO. It then performs SRAM write cycles into the two 32 KB VRAM chips or the dual-port palette RAM, only while the VGA timing grants the bus. It drives the DMA side of the gfx address muxes and the data bus drivers.

---
 rtl/gfx_pkg.sv | 34 +++
 rtl/gfx_dma_fifo.sv | 60 ++++++
 rtl/gfx_dma_writer.sv | 177 +++++++++++++++++
 tb/tb_gfx_dma_writer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the gfx DMA write path.
// Holds register offsets, CTRL bits, FSM states, targets and chip selects.
package gfx_pkg;

   localparam logic [1:0] REG_ADDR_LO = 2'd0;
   localparam logic [1:0] REG_ADDR_HI = 2'd1;
   localparam logic [1:0] REG_DATA    = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int CTRL_TARGET  = 0;
   localparam int CTRL_AUTO    = 1;
   localparam int CTRL_OVF_CLR = 7;

   localparam logic [7:0] CTRL_RESET = 8'h02;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD
   } wr_state_t;

   localparam logic TGT_VRAM = 1'b0;
   localparam logic TGT_PAL  = 1'b1;

   localparam logic [1:0] VRAM_CE_NONE  = 2'b11;
   localparam logic [1:0] VRAM_CE_CHIP0 = 2'b10;
   localparam logic [1:0] VRAM_CE_CHIP1 = 2'b01;

   function automatic logic [1:0] vram_ce(input logic hi_bit);
      return hi_bit ? VRAM_CE_CHIP1 : VRAM_CE_CHIP0;
   endfunction

endpackage

// File: rtl/gfx_dma_fifo.sv
// Synchronous write-buffer FIFO for the gfx DMA writer.
// Ports: clk, rst, push/wr_data, pop/rd_data, full, empty, count.
module gfx_dma_fifo #(
   parameter int Width = 25,
   parameter int Depth = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [Width-1:0]           wr_data,
   input  logic                       pop,
   output logic [Width-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth):0]     count
);

   localparam int PW = $clog2(Depth);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(Depth);

   logic [Width-1:0] mem [Depth];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same edge, so a full FIFO still accepts.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gfx_dma_writer.sv
// CPU-side DMA write engine: buffers byte writes, drives VRAM/palette SRAM cycles.
// Ports: CPU reg port in, dma window in, SRAM address/enables/data out, status out.
module gfx_dma_writer
   import gfx_pkg::*;
#(
   parameter int FifoDepth    = 4,
   parameter int AddrWidth    = 16,
   parameter int PalAddrWidth = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cpu_cs,
   input  logic [1:0]           i_cpu_reg,
   input  logic [7:0]           i_cpu_data,
   input  logic                 i_dma_window,
   output logic                 o_addr_sel,
   output logic [AddrWidth-1:0] o_dma_addr,
   output logic [1:0]           o_vram_ce_b,
   output logic                 o_pal_ce_b,
   output logic                 o_we_b,
   output logic [7:0]           o_data,
   output logic                 o_data_oe_b,
   output logic                 o_busy,
   output logic                 o_full,
   output logic                 o_overflow
);

   localparam int EW = 1 + AddrWidth + 8;
   localparam int CW = $clog2(FifoDepth) + 1;
   localparam int PZ = AddrWidth - PalAddrWidth;

   logic                 req_cs;
   logic [1:0]           req_reg;
   logic [7:0]           req_data;
   logic [AddrWidth-1:0] ptr;
   logic                 ctrl_target;
   logic                 ctrl_auto;

   logic                 is_data;
   logic                 do_push;
   logic                 pop;
   logic [AddrWidth-1:0] pal_addr;
   logic [AddrWidth-1:0] push_addr;
   logic [AddrWidth-1:0] ptr_inc;
   logic [EW-1:0]        push_entry;

   logic [EW-1:0]        head;
   logic                 head_target;
   logic [AddrWidth-1:0] head_addr;
   logic [7:0]           head_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic [CW-1:0]        cnt_nxt;

   wr_state_t            state;
   logic                 start;

   // CPU accesses are registered first; all decode works off that stage.
   assign is_data   = req_cs && (req_reg == REG_DATA);
   assign pop       = (state == S_STROBE);
   assign do_push   = is_data && (!fifo_full || pop);
   assign pal_addr  = {{PZ{1'b0}}, ptr[PalAddrWidth-1:0]};
   assign push_addr = (ctrl_target == TGT_PAL) ? pal_addr : ptr;
   assign ptr_inc   = (ctrl_target == TGT_PAL)
                    ? {{PZ{1'b0}}, ptr[PalAddrWidth-1:0] + 1'b1}
                    : ptr + 1'b1;
   assign push_entry = {ctrl_target, push_addr, req_data};

   assign {head_target, head_addr, head_data} = head;
   assign cnt_nxt = fifo_count + CW'(do_push) - CW'(pop);
   assign start   = !fifo_empty && i_dma_window;
   assign o_full  = fifo_full;

   gfx_dma_fifo #(
      .Width (EW),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk     (i_clk),
      .rst     (i_rst),
      .push    (do_push),
      .wr_data (push_entry),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         req_cs      <= 1'b0;
         req_reg     <= '0;
         req_data    <= '0;
         ptr         <= '0;
         ctrl_target <= CTRL_RESET[CTRL_TARGET];
         ctrl_auto   <= CTRL_RESET[CTRL_AUTO];
         o_overflow  <= 1'b0;
      end else begin
         req_cs   <= i_cpu_cs;
         req_reg  <= i_cpu_reg;
         req_data <= i_cpu_data;
         if (req_cs) begin
            unique case (req_reg)
               REG_ADDR_LO: ptr[7:0] <= req_data;
               REG_ADDR_HI: ptr[AddrWidth-1:8] <= req_data[AddrWidth-9:0];
               REG_DATA: begin
                  if (!do_push) begin
                     o_overflow <= 1'b1;
                  end else if (ctrl_auto) begin
                     ptr <= ptr_inc;
                  end
               end
               REG_CTRL: begin
                  ctrl_target <= req_data[CTRL_TARGET];
                  ctrl_auto   <= req_data[CTRL_AUTO];
                  if (req_data[CTRL_OVF_CLR]) begin
                     o_overflow <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   // The entry is popped leaving STROBE: the output registers already
   // hold it, so HOLD can look straight at the next head.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         o_addr_sel  <= 1'b0;
         o_dma_addr  <= '0;
         o_vram_ce_b <= VRAM_CE_NONE;
         o_pal_ce_b  <= 1'b1;
         o_we_b      <= 1'b1;
         o_data      <= '0;
         o_data_oe_b <= 1'b1;
         o_busy      <= 1'b0;
      end else begin
         o_busy <= (cnt_nxt != '0);
         unique case (state)
            S_IDLE, S_HOLD: begin
               o_we_b <= 1'b1;
               if (start) begin
                  state       <= S_SETUP;
                  o_busy      <= 1'b1;
                  o_addr_sel  <= 1'b1;
                  o_dma_addr  <= head_addr;
                  o_data      <= head_data;
                  o_data_oe_b <= 1'b0;
                  o_pal_ce_b  <= (head_target != TGT_PAL);
                  o_vram_ce_b <= (head_target == TGT_PAL)
                               ? VRAM_CE_NONE
                               : vram_ce(head_addr[AddrWidth-1]);
               end else begin
                  state       <= S_IDLE;
                  o_addr_sel  <= 1'b0;
                  o_vram_ce_b <= VRAM_CE_NONE;
                  o_pal_ce_b  <= 1'b1;
                  o_data_oe_b <= 1'b1;
               end
            end
            S_SETUP: begin
               state  <= S_STROBE;
               o_we_b <= 1'b0;
               o_busy <= 1'b1;
            end
            S_STROBE: begin
               state  <= S_HOLD;
               o_we_b <= 1'b1;
               o_busy <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gfx_dma_writer.sv
// Self-checking bench for gfx_dma_writer.
// Scoreboard of expected SRAM writes plus directed timing checks.
module tb_gfx_dma_writer;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_cpu_cs = 1'b0;
   logic [1:0]  i_cpu_reg = '0;
   logic [7:0]  i_cpu_data = '0;
   logic        i_dma_window = 1'b0;
   logic        o_addr_sel;
   logic [15:0] o_dma_addr;
   logic [1:0]  o_vram_ce_b;
   logic        o_pal_ce_b;
   logic        o_we_b;
   logic [7:0]  o_data;
   logic        o_data_oe_b;
   logic        o_busy;
   logic        o_full;
   logic        o_overflow;

   gfx_dma_writer dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_cpu_cs     (i_cpu_cs),
      .i_cpu_reg    (i_cpu_reg),
      .i_cpu_data   (i_cpu_data),
      .i_dma_window (i_dma_window),
      .o_addr_sel   (o_addr_sel),
      .o_dma_addr   (o_dma_addr),
      .o_vram_ce_b  (o_vram_ce_b),
      .o_pal_ce_b   (o_pal_ce_b),
      .o_we_b       (o_we_b),
      .o_data       (o_data),
      .o_data_oe_b  (o_data_oe_b),
      .o_busy       (o_busy),
      .o_full       (o_full),
      .o_overflow   (o_overflow)
   );

   always #20 clk = ~clk;

   typedef struct {
      bit pal;
      int addr;
      int data;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] vram_m[int];
   logic [7:0] pal_m[int];
   int         strobe_cyc[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         n_strobe = 0;
   int         cyc = 0;
   bit         chk_en = 1'b0;

   int m_ptr = 0;
   bit m_pal = 0;
   bit m_auto = 1;

   logic [15:0] p_addr = '0;
   logic        p_we = 1'b1;
   logic        p_sel = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      logic [1:0] ece;
      if (chk_en && !i_rst) begin
         if (o_we_b == 1'b0) begin
            if (expq.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = expq.pop_front();
               if (e.pal) ece = 2'b11;
               else if (e.addr >= 32768) ece = 2'b01;
               else ece = 2'b10;
               chk("wr_addr", o_dma_addr, e.addr);
               chk("wr_data", o_data, e.data);
               chk("wr_vram_ce", o_vram_ce_b, ece);
               chk("wr_pal_ce", o_pal_ce_b, e.pal ? 0 : 1);
               chk("wr_oe", o_data_oe_b, 0);
               chk("wr_sel", o_addr_sel, 1);
               chk("setup_addr", p_addr, e.addr);
               chk("setup_we", p_we, 1);
               chk("setup_sel", p_sel, 1);
               if (e.pal) pal_m[e.addr] = o_data;
               else vram_m[e.addr] = o_data;
            end
            n_strobe++;
            strobe_cyc.push_back(cyc);
         end
         if (o_addr_sel == 1'b0) begin
            chk("idle_bus", {o_vram_ce_b, o_pal_ce_b, o_data_oe_b, o_we_b},
                5'b11111);
         end
      end
      p_addr = o_dma_addr;
      p_we   = o_we_b;
      p_sel  = o_addr_sel;
   end

   task automatic cpu_wr(input logic [1:0] r, input logic [7:0] d);
      @(negedge clk);
      i_cpu_cs   = 1'b1;
      i_cpu_reg  = r;
      i_cpu_data = d;
      @(posedge clk);
      #1;
      i_cpu_cs = 1'b0;
      case (r)
         2'd0: m_ptr = (m_ptr / 256) * 256 + d;
         2'd1: m_ptr = (m_ptr % 256) + d * 256;
         2'd3: begin
            m_pal  = d[0];
            m_auto = d[1];
         end
         default: begin
            if (expq.size() < 4) begin
               expq.push_back('{m_pal, m_pal ? m_ptr % 1024 : m_ptr, d});
               if (m_auto) begin
                  if (m_pal) m_ptr = (m_ptr % 1024 + 1) % 1024;
                  else m_ptr = (m_ptr + 1) % 65536;
               end
            end
         end
      endcase
   endtask

   task automatic wait_idle(input int max);
      bit done = 0;
      for (int i = 0; i < max && !done; i++) begin
         @(negedge clk);
         if (!o_busy && expq.size() == 0) done = 1;
      end
      chk("idle_timeout", done, 1);
   endtask

   task automatic wait_we(input int max);
      bit seen = 0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (o_we_b == 1'b0) seen = 1;
      end
      chk("we_timeout", seen, 1);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", o_addr_sel, 0);
      chk("rst_addr", o_dma_addr, 16'h0000);
      chk("rst_vce", o_vram_ce_b, 2'b11);
      chk("rst_pce", o_pal_ce_b, 1);
      chk("rst_we", o_we_b, 1);
      chk("rst_oe", o_data_oe_b, 1);
      chk("rst_data", o_data, 0);
      chk("rst_flags", {o_busy, o_full, o_overflow}, 3'b000);
      @(negedge clk);
      i_rst = 1'b0;
      chk_en = 1'b1;
      i_dma_window = 1'b1;

      // Single write with literal cycle-by-cycle expectations.
      cpu_wr(2'd0, 8'h34);
      cpu_wr(2'd1, 8'h12);
      cpu_wr(2'd2, 8'hAB);
      after_edge();
      chk("t1_n1_sel", o_addr_sel, 0);
      chk("t1_n1_busy", o_busy, 1);
      after_edge();
      chk("t1_n2_sel", o_addr_sel, 1);
      chk("t1_n2_addr", o_dma_addr, 16'h1234);
      chk("t1_n2_vce", o_vram_ce_b, 2'b10);
      chk("t1_n2_data", o_data, 8'hAB);
      chk("t1_n2_oe", o_data_oe_b, 0);
      chk("t1_n2_we", o_we_b, 1);
      after_edge();
      chk("t1_n3_we", o_we_b, 0);
      after_edge();
      chk("t1_n4_we", o_we_b, 1);
      chk("t1_n4_sel", o_addr_sel, 1);
      chk("t1_n4_addr", o_dma_addr, 16'h1234);
      after_edge();
      chk("t1_n5_sel", o_addr_sel, 0);
      chk("t1_n5_busy", o_busy, 0);
      chk("t1_n5_vce", o_vram_ce_b, 2'b11);
      chk("t1_ram", vram_m.exists(32'h1234) ? vram_m[32'h1234] : 8'hxx,
          8'hAB);

      // Auto-increment across the VRAM wrap point.
      cpu_wr(2'd0, 8'hFF);
      cpu_wr(2'd1, 8'hFF);
      cpu_wr(2'd2, 8'h11);
      cpu_wr(2'd2, 8'h22);
      wait_idle(40);
      chk("t2_ffff", vram_m.exists(32'hFFFF) ? vram_m[32'hFFFF] : 8'hxx,
          8'h11);
      chk("t2_0000", vram_m.exists(0) ? vram_m[0] : 8'hxx, 8'h22);

      // Palette pointer masked and wrapping at 10 bits.
      cpu_wr(2'd3, 8'h03);
      cpu_wr(2'd0, 8'hFF);
      cpu_wr(2'd1, 8'h03);
      cpu_wr(2'd2, 8'h33);
      cpu_wr(2'd2, 8'h44);
      wait_idle(40);
      chk("t3_3ff", pal_m.exists(32'h3FF) ? pal_m[32'h3FF] : 8'hxx, 8'h33);
      chk("t3_000", pal_m.exists(0) ? pal_m[0] : 8'hxx, 8'h44);
      cpu_wr(2'd3, 8'h02);

      // Closed window: fill, overflow, then drain at 3-cycle spacing.
      i_dma_window = 1'b0;
      cpu_wr(2'd0, 8'h00);
      cpu_wr(2'd1, 8'h01);
      s0 = strobe_cyc.size();
      for (int i = 0; i < 5; i++) cpu_wr(2'd2, 8'hA0 + 8'(i));
      repeat (3) @(negedge clk);
      chk("t4_full", o_full, 1);
      chk("t4_ovf", o_overflow, 1);
      chk("t4_busy", o_busy, 1);
      chk("t4_sel", o_addr_sel, 0);
      chk("t4_nowr", strobe_cyc.size() - s0, 0);
      chk("t4_queued", expq.size(), 4);
      i_dma_window = 1'b1;
      wait_idle(60);
      chk("t4_nwr", strobe_cyc.size() - s0, 4);
      for (int i = s0 + 1; i < strobe_cyc.size(); i++)
         chk("t4_spacing", strobe_cyc[i] - strobe_cyc[i-1], 3);
      chk("t4_last", vram_m.exists(32'h103) ? vram_m[32'h103] : 8'hxx,
          8'hA3);
      chk("t4_full_clr", o_full, 0);
      chk("t4_ovf_sticky", o_overflow, 1);
      cpu_wr(2'd3, 8'h82);
      after_edge();
      chk("t4_ovf_clr", o_overflow, 0);
      cpu_wr(2'd2, 8'hA5);
      wait_idle(40);
      chk("t4_ptr_kept", vram_m.exists(32'h104) ? vram_m[32'h104] : 8'hxx,
          8'hA5);

      // Window falls during STROBE: that cycle completes, rest held.
      cpu_wr(2'd0, 8'h00);
      cpu_wr(2'd1, 8'h20);
      s0 = n_strobe;
      cpu_wr(2'd2, 8'h51);
      cpu_wr(2'd2, 8'h52);
      cpu_wr(2'd2, 8'h53);
      wait_we(20);
      i_dma_window = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_one_wr", n_strobe - s0, 1);
      chk("t5_busy", o_busy, 1);
      chk("t5_sel", o_addr_sel, 0);
      chk("t5_held", expq.size(), 2);
      i_dma_window = 1'b1;
      wait_idle(40);
      chk("t5_2001", vram_m.exists(32'h2001) ? vram_m[32'h2001] : 8'hxx,
          8'h52);
      chk("t5_2002", vram_m.exists(32'h2002) ? vram_m[32'h2002] : 8'hxx,
          8'h53);

      // Reset during STROBE aborts the cycle and flushes the FIFO.
      cpu_wr(2'd0, 8'h00);
      cpu_wr(2'd1, 8'h30);
      cpu_wr(2'd2, 8'h61);
      cpu_wr(2'd2, 8'h62);
      wait_we(20);
      i_rst = 1'b1;
      chk_en = 1'b0;
      after_edge();
      chk("t6_we", o_we_b, 1);
      chk("t6_vce", o_vram_ce_b, 2'b11);
      chk("t6_pce", o_pal_ce_b, 1);
      chk("t6_oe", o_data_oe_b, 1);
      chk("t6_sel", o_addr_sel, 0);
      chk("t6_flags", {o_busy, o_full, o_overflow}, 3'b000);
      expq.delete();
      m_ptr = 0;
      m_pal = 0;
      m_auto = 1;
      @(negedge clk);
      i_rst = 1'b0;
      chk_en = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_flushed", {o_busy, o_addr_sel}, 2'b00);
      cpu_wr(2'd2, 8'h77);
      wait_idle(40);
      chk("t6_ptr_rst", vram_m.exists(0) ? vram_m[0] : 8'hxx, 8'h77);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got expired expected finished");
      $fatal(1, "timeout");
   end

endmodule
